// File: rtl/register_file.sv
// Register file with a pending-write scoreboard, optional write-to-read
// forwarding, a halt freeze and a wrapping committed-write counter.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_value,
  input  logic [ADDR_WIDTH-1:0] read_reg_a,
  input  logic [ADDR_WIDTH-1:0] read_reg_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  mark_pending,
  input  logic [ADDR_WIDTH-1:0] mark_reg,
  input  logic                  halt,
  output logic                  stall,
  output logic [15:0]           write_count
);

  localparam logic L_BYPASS = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pending;
  logic [15:0]           r_write_count;

  logic w_commit;
  logic w_mark;
  logic w_fwd_a;
  logic w_fwd_b;
  logic w_stall_a;
  logic w_stall_b;

  // Qualify write and mark requests: index 0 and halt suppress both.
  always_comb begin
    w_commit = write_enable && !halt && (write_reg != '0);
    w_mark   = mark_pending && !halt && (mark_reg != '0);
  end

  // Forwarding applies only to a same-cycle commit to the read index.
  always_comb begin
    w_fwd_a = L_BYPASS && w_commit && (read_reg_a == write_reg);
    w_fwd_b = L_BYPASS && w_commit && (read_reg_b == write_reg);
  end

  // Combinational read ports; register 0 is hard-wired to zero.
  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    if (w_fwd_a)
      read_data_a = write_value;
    else if (read_reg_a != '0)
      read_data_a = r_regs[read_reg_a];
    if (w_fwd_b)
      read_data_b = write_value;
    else if (read_reg_b != '0)
      read_data_b = r_regs[read_reg_b];
  end

  // Stall on an outstanding producer unless this cycle's forwarded commit resolves it.
  always_comb begin
    w_stall_a = (read_reg_a != '0) && r_pending[read_reg_a] && !w_fwd_a;
    w_stall_b = (read_reg_b != '0) && r_pending[read_reg_b] && !w_fwd_b;
    stall     = w_stall_a || w_stall_b;
  end

  // Architectural state update: reset overrides everything, halt freezes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_pending     <= '0;
      r_write_count <= '0;
    end else if (!halt) begin
      if (w_commit) begin
        r_regs[write_reg] <= write_value;
        r_write_count     <= r_write_count + 16'd1;
      end
      // Clear on commit first, then set on mark, so a same-cycle mark from a
      // newer producer keeps the bit set.
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_mark && (mark_reg == ADDR_WIDTH'(i)))
          r_pending[i] <= 1'b1;
        else if (w_commit && (write_reg == ADDR_WIDTH'(i)))
          r_pending[i] <= 1'b0;
      end
    end
  end

  assign write_count = r_write_count;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one forwarding and one non-forwarding
// instance share the same stimulus.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [2:0]  write_reg;
  logic [31:0] write_value;
  logic [2:0]  read_reg_a;
  logic [2:0]  read_reg_b;
  logic        mark_pending;
  logic [2:0]  mark_reg;
  logic        halt;

  logic [31:0] rda_b, rdb_b, rda_n, rdb_n;
  logic        stall_b, stall_n;
  logic [15:0] wc_b, wc_n;

  int n_cmp = 0;
  int n_bad = 0;

  register_file #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(3), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_reg(write_reg),
    .write_value(write_value), .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
    .read_data_a(rda_b), .read_data_b(rdb_b), .mark_pending(mark_pending),
    .mark_reg(mark_reg), .halt(halt), .stall(stall_b), .write_count(wc_b));

  register_file #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(3), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_reg(write_reg),
    .write_value(write_value), .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
    .read_data_a(rda_n), .read_data_b(rdb_n), .mark_pending(mark_pending),
    .mark_reg(mark_reg), .halt(halt), .stall(stall_n), .write_count(wc_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    mark_pending = 1'b0;
    halt         = 1'b0;
    reset        = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; write_reg = '0; write_value = '0;
    read_reg_a = 3'd3; read_reg_b = 3'd5; mark_pending = 1'b0; mark_reg = '0; halt = 1'b0;
    tick();
    idle();
    #1;
    check("rst_rda", rda_b, 32'h0);
    check("rst_rdb", rdb_b, 32'h0);
    check("rst_stall", {31'b0, stall_b}, 32'h0);
    check("rst_wc", {16'b0, wc_b}, 32'h0);

    // Write r3 and read it back next cycle.
    write_enable = 1'b1; write_reg = 3'd3; write_value = 32'h0000_1234;
    tick();
    idle(); read_reg_a = 3'd3; #1;
    check("r3_read", rda_b, 32'h0000_1234);
    check("r3_wc", {16'b0, wc_b}, 32'd1);

    // Writes to r0 are discarded and not counted.
    write_enable = 1'b1; write_reg = 3'd0; write_value = 32'hFFFF_FFFF; read_reg_a = 3'd0;
    #1;
    check("r0_same", rda_b, 32'h0);
    tick();
    idle(); #1;
    check("r0_read", rda_b, 32'h0);
    check("r0_wc", {16'b0, wc_b}, 32'd1);

    // Same-cycle write/read of r5: forwarded vs old value.
    write_enable = 1'b1; write_reg = 3'd5; write_value = 32'hA5A5_A5A5; read_reg_b = 3'd5;
    #1;
    check("byp_rdb", rdb_b, 32'hA5A5_A5A5);
    check("nobyp_rdb_old", rdb_n, 32'h0);
    tick();
    idle(); #1;
    check("nobyp_rdb_new", rdb_n, 32'hA5A5_A5A5);
    check("r5_wc", {16'b0, wc_n}, 32'd2);

    // Scoreboard: mark r2, then read it.
    read_reg_b = 3'd0;
    mark_pending = 1'b1; mark_reg = 3'd2;
    tick();
    idle(); read_reg_a = 3'd2; #1;
    check("mark_stall_b", {31'b0, stall_b}, 32'd1);
    check("mark_stall_n", {31'b0, stall_n}, 32'd1);
    write_enable = 1'b1; write_reg = 3'd2; write_value = 32'd7;
    #1;
    check("commit_stall_b", {31'b0, stall_b}, 32'd0);
    check("commit_stall_n", {31'b0, stall_n}, 32'd1);
    check("commit_rda_b", rda_b, 32'd7);
    tick();
    idle(); #1;
    check("after_stall_n", {31'b0, stall_n}, 32'd0);
    check("after_rda_n", rda_n, 32'd7);

    // Mark and commit r2 together: pending stays set.
    write_enable = 1'b1; write_reg = 3'd2; write_value = 32'd8;
    mark_pending = 1'b1; mark_reg = 3'd2;
    tick();
    idle(); #1;
    check("markcommit_stall", {31'b0, stall_b}, 32'd1);
    check("markcommit_rda", rda_b, 32'd8);
    write_enable = 1'b1; write_reg = 3'd2; write_value = 32'd8;
    tick();
    idle(); #1;
    check("clear_stall", {31'b0, stall_b}, 32'd0);
    check("clear_wc", {16'b0, wc_b}, 32'd5);

    // Halt freezes writes, marks and the counter; reads stay valid.
    halt = 1'b1; write_enable = 1'b1; write_reg = 3'd4; write_value = 32'd9;
    mark_pending = 1'b1; mark_reg = 3'd6; read_reg_a = 3'd3; read_reg_b = 3'd4;
    #1;
    check("halt_rda", rda_b, 32'h0000_1234);
    check("halt_rdb_nofwd", rdb_b, 32'h0);
    tick();
    idle(); read_reg_a = 3'd4; read_reg_b = 3'd6; #1;
    check("halt_r4", rda_b, 32'h0);
    check("halt_pend6", {31'b0, stall_b}, 32'd0);
    check("halt_wc", {16'b0, wc_b}, 32'd5);
    write_enable = 1'b1; write_reg = 3'd4; write_value = 32'd9;
    tick();
    idle(); #1;
    check("unhalt_r4", rda_b, 32'd9);
    check("unhalt_wc", {16'b0, wc_b}, 32'd6);

    // Marking r0 has no effect.
    mark_pending = 1'b1; mark_reg = 3'd0;
    tick();
    idle(); read_reg_a = 3'd0; read_reg_b = 3'd0; #1;
    check("mark0_stall", {31'b0, stall_b}, 32'd0);

    // Counter wrap: 65536 writes after reset.
    reset = 1'b1;
    tick();
    idle();
    write_enable = 1'b1; write_reg = 3'd1;
    for (int i = 0; i < 65535; i++) begin
      write_value = 32'(i);
      tick();
    end
    check("wc_ffff", {16'b0, wc_b}, 32'h0000_FFFF);
    tick();
    idle(); #1;
    check("wc_wrap", {16'b0, wc_b}, 32'h0);

    // Reset mid-sequence discards concurrent write and pending state.
    mark_pending = 1'b1; mark_reg = 3'd7;
    tick();
    idle(); read_reg_b = 3'd7; #1;
    check("pre_rst_stall", {31'b0, stall_b}, 32'd1);
    reset = 1'b1; write_enable = 1'b1; write_reg = 3'd1; write_value = 32'd3;
    tick();
    idle(); read_reg_a = 3'd1; #1;
    check("rst_r1", rda_b, 32'h0);
    check("rst_r1_n", rda_n, 32'h0);
    check("rst_pend7", {31'b0, stall_b}, 32'd0);
    check("rst_wc2", {16'b0, wc_b}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
